edge_bbox_tracker: RTL
======================

# edge_bbox_tracker

Downstream consumer of the single-channel edge convolution stage in the paddle-localization pipeline. Takes the thresholded 12-bit edge stream plus its valid, tracks raster position, and accumulates the bounding box and hit count of edge pixels over one frame. At end of frame it publishes the paddle box, its centre and a found flag for the game/overlay logic.

## Interface
Parameters:
- LINE_WIDTH, 640, valid pixels per line.
- FRAME_HEIGHT, 480, lines per frame.
- PIXEL_DEPTH, 12, input pixel width; matches the edge stage output width.
- HIT_LEVEL, 4095, a pixel is a hit when pixel_i >= HIT_LEVEL.
- MIN_COUNT, 16, minimum hits for found_o.
- X_W = $clog2(LINE_WIDTH), Y_W = $clog2(FRAME_HEIGHT), CNT_W = X_W+Y_W (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  pixel_i valid this cycle; this is the edge stage's valid_o.
- sof_i  in  1  start of frame, qualified by valid_i, marks pixel (0,0).
- pixel_i  in  PIXEL_DEPTH  edge magnitude; this is the edge stage's outputG.
- bbox_valid_o  out  1  one-cycle pulse when results update.
- found_o  out  1  hit count >= MIN_COUNT.
- x_min_o, x_max_o  out  X_W  box columns.
- y_min_o, y_max_o  out  Y_W  box rows.
- cx_o  out  X_W  (x_min+x_max)>>1.
- cy_o  out  Y_W  (y_min+y_max)>>1.
- count_o  out  CNT_W  hit count, saturating.

## Operation
- FSM in two states. IDLE waits for a frame start. ACCUM accumulates a frame.
- Beat = valid_i high. Cycles with valid_i low change nothing: no counter, accumulator or state update.
- IDLE: a beat with sof_i high moves to ACCUM. That beat is processed as pixel (0,0). Beats without sof_i are ignored.
- ACCUM: each beat advances x. At x=LINE_WIDTH-1, x wraps to 0 and y increments.
- Hit on a beat: count increments, saturating at all-ones. x_min, x_max, y_min and y_max update.
- First hit of a frame loads all four bounds from its coordinates. Later hits update bounds with min/max compares.
- Last pixel is x=LINE_WIDTH-1, y=FRAME_HEIGHT-1. On that beat the result registers load. The loaded values include that pixel's own hit, merged combinationally.
- On the last-pixel beat the accumulators clear and the FSM returns to IDLE.
- sof_i on a beat while in ACCUM aborts the frame with no report. Accumulators restart and that beat counts as (0,0).
- Result load when count >= MIN_COUNT: found_o=1, bounds and centres come from the accumulators.
- Result load when count < MIN_COUNT: found_o=0, all bounds and centres are 0. count_o always carries the true count.
- Centre sums use X_W+1 / Y_W+1 bits before the shift, so no overflow.
- Result outputs hold until the next load.
- reset at any time, including mid-frame:
  - FSM goes to IDLE.
  - Counters and accumulators clear.
  - All outputs clear; bbox_valid_o=0, found_o=0.

## Timing
- All outputs are registered.
- bbox_valid_o is high exactly in the cycle after the clock edge that accepted the last pixel. Result outputs are valid in that same cycle.
- Latency is 1 clock from the last-pixel beat to results.
- Back-to-back frames: a sof_i beat may arrive in the cycle directly after the last pixel, while bbox_valid_o is high. It must be accepted without a lost pixel, because IDLE is entered on the last-pixel edge.
- Throughput is 1 pixel/clock sustained. Gaps in valid_i are allowed anywhere.
- After reset, outputs are 0 from the first cycle with reset low. The first sof_i beat is accepted on that same cycle.

## Structure
- Package paddle_loc_pkg holds:
  - the state enum {IDLE, ACCUM};
  - HIT_LEVEL and MIN_COUNT defaults;
  - a width helper function shared with other localization stages.
- Sub-module raster_counter holds the x/y counters with wrap and the last-pixel flag. Its inputs are clk, reset, beat and restart; its outputs are x, y and last.
- The box accumulator and result registers stay in edge_bbox_tracker.

## Test plan
Bench parameters: LINE_WIDTH=8, FRAME_HEIGHT=6, MIN_COUNT=2, HIT_LEVEL=4095.
- Hits 4095 at (2,1), (5,4), (3,3); all other pixels 0 -> one pulse; box x 2..5, y 1..4; cx=3, cy=2; count=3; found=1.
- One hit at (7,5), the last pixel -> count=1, found=0, bounds 0. Repeat with MIN_COUNT=1 -> box (7,7,5,5), proving the last-pixel merge.
- Value 4094 everywhere -> count=0, found=0; pulse still occurs.
- Random valid_i gaps of 0–3 cycles over the first scenario -> identical results.
- sof_i reasserted at pixel 20 of a frame with hits before it -> no pulse; results reflect only the new frame.
- Two frames back-to-back, second sof_i in the pulse cycle -> two pulses 48 beats apart with independent boxes.
- reset mid-frame -> outputs 0 next cycle; ignored until sof_i.

Source files
------------

// File: rtl/paddle_loc_pkg.sv
// Shared types and defaults for the paddle-localization pipeline stages.
package paddle_loc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   localparam int HIT_LEVEL_DEFAULT = 4095;
   localparam int MIN_COUNT_DEFAULT = 16;

   // Index width for a range of n values; never returns zero so degenerate sizes still elaborate.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position of the current beat; restart forces this beat to (0,0).
module raster_counter
   import paddle_loc_pkg::*;
#(
   parameter int LINE_WIDTH   = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int X_W          = width_of(LINE_WIDTH),
   parameter int Y_W          = width_of(FRAME_HEIGHT)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           beat,
   input  logic           restart,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_HEIGHT - 1);

   logic [X_W-1:0] x_q;
   logic [Y_W-1:0] y_q;

   // x/y are the coordinates of the beat presented this cycle, not of the next one.
   always_comb begin
      x    = restart ? '0 : x_q;
      y    = restart ? '0 : y_q;
      last = (x == X_LAST) && (y == Y_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else if (beat) begin
         if (x == X_LAST) begin
            x_q <= '0;
            y_q <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x_q <= x + 1'b1;
            y_q <= y;
         end
      end
   end

endmodule

// File: rtl/edge_bbox_tracker.sv
// Accumulates the bounding box and hit count of edge pixels per frame and
// publishes box, centre and found flag one clock after the last pixel.
module edge_bbox_tracker
   import paddle_loc_pkg::*;
#(
   parameter int  LINE_WIDTH   = 640,
   parameter int  FRAME_HEIGHT = 480,
   parameter int  PIXEL_DEPTH  = 12,
   parameter int  HIT_LEVEL    = HIT_LEVEL_DEFAULT,
   parameter int  MIN_COUNT    = MIN_COUNT_DEFAULT,
   localparam int X_W          = width_of(LINE_WIDTH),
   localparam int Y_W          = width_of(FRAME_HEIGHT),
   localparam int CNT_W        = X_W + Y_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_i,
   input  logic                   sof_i,
   input  logic [PIXEL_DEPTH-1:0] pixel_i,
   output logic                   bbox_valid_o,
   output logic                   found_o,
   output logic [X_W-1:0]         x_min_o,
   output logic [X_W-1:0]         x_max_o,
   output logic [Y_W-1:0]         y_min_o,
   output logic [Y_W-1:0]         y_max_o,
   output logic [X_W-1:0]         cx_o,
   output logic [Y_W-1:0]         cy_o,
   output logic [CNT_W-1:0]       count_o
);

   localparam logic [PIXEL_DEPTH-1:0] HIT_THR = PIXEL_DEPTH'(HIT_LEVEL);
   localparam logic [CNT_W:0]         MIN_CNT = (CNT_W + 1)'(MIN_COUNT);

   // Input has no back-pressure: a beat is any cycle with valid_i high, sof_i is only
   // meaningful on a beat, and cycles with valid_i low leave every register untouched.
   state_t state, state_next;
   logic   beat, restart, last;

   logic [X_W-1:0]   x, x_min_q, x_max_q, x_min_n, x_max_n;
   logic [Y_W-1:0]   y, y_min_q, y_max_q, y_min_n, y_max_n;
   logic [CNT_W-1:0] cnt_q, cnt_n, base_cnt;
   logic             hit, found_n;
   logic [X_W:0]     cx_sum;
   logic [Y_W:0]     cy_sum;

   raster_counter #(
      .LINE_WIDTH   (LINE_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT),
      .X_W          (X_W),
      .Y_W          (Y_W)
   ) u_raster (
      .clk     (clk),
      .reset   (reset),
      .beat    (beat),
      .restart (restart),
      .x       (x),
      .y       (y),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (beat) state_next = last ? IDLE : ACCUM;
   end

   always_comb begin
      restart = valid_i && sof_i;
      beat    = valid_i && ((state == ACCUM) || sof_i);
   end

   assign hit = pixel_i >= HIT_THR;

   // Merge this beat into the running box so the last pixel's own hit reaches the results.
   always_comb begin
      base_cnt = restart ? '0 : cnt_q;
      cnt_n    = base_cnt;
      x_min_n  = restart ? '0 : x_min_q;
      x_max_n  = restart ? '0 : x_max_q;
      y_min_n  = restart ? '0 : y_min_q;
      y_max_n  = restart ? '0 : y_max_q;
      if (hit) begin
         cnt_n = (&base_cnt) ? base_cnt : base_cnt + 1'b1;
         if (base_cnt == '0) begin
            x_min_n = x;
            x_max_n = x;
            y_min_n = y;
            y_max_n = y;
         end else begin
            if (x < x_min_n) x_min_n = x;
            if (x > x_max_n) x_max_n = x;
            if (y < y_min_n) y_min_n = y;
            if (y > y_max_n) y_max_n = y;
         end
      end
      found_n = {1'b0, cnt_n} >= MIN_CNT;
      cx_sum  = {1'b0, x_min_n} + {1'b0, x_max_n};
      cy_sum  = {1'b0, y_min_n} + {1'b0, y_max_n};
   end

   always_ff @(posedge clk) begin
      if (reset || (beat && last)) begin
         cnt_q   <= '0;
         x_min_q <= '0;
         x_max_q <= '0;
         y_min_q <= '0;
         y_max_q <= '0;
      end else if (beat) begin
         cnt_q   <= cnt_n;
         x_min_q <= x_min_n;
         x_max_q <= x_max_n;
         y_min_q <= y_min_n;
         y_max_q <= y_max_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bbox_valid_o <= 1'b0;
         found_o      <= 1'b0;
         x_min_o      <= '0;
         x_max_o      <= '0;
         y_min_o      <= '0;
         y_max_o      <= '0;
         cx_o         <= '0;
         cy_o         <= '0;
         count_o      <= '0;
      end else begin
         bbox_valid_o <= beat && last;
         if (beat && last) begin
            found_o <= found_n;
            count_o <= cnt_n;
            x_min_o <= found_n ? x_min_n : '0;
            x_max_o <= found_n ? x_max_n : '0;
            y_min_o <= found_n ? y_min_n : '0;
            y_max_o <= found_n ? y_max_n : '0;
            cx_o    <= found_n ? cx_sum[X_W:1] : '0;
            cy_o    <= found_n ? cy_sum[Y_W:1] : '0;
         end
      end
   end

endmodule
